// File: rtl/la_reduce_pipe.sv
// rtl/la_reduce_pipe.sv - pipelined FANIN-ary reduction gate with valid/ready flow control
//
// Reduces an N-bit operand with AND/NAND/OR/NOR/XOR/XNOR through a tree of
// FANIN-input nodes. A register stage follows every tree level, so a result
// appears L = ceil(log_FANIN(N)) cycles (min 1) after the operand is accepted.
//
// Ports:
//   clk        clock, all state on posedge
//   nreset     asynchronous active-low reset
//   in         N-bit operand, taken when in_valid & in_ready
//   in_valid   operand valid
//   in_ready   pipeline can take an operand this cycle
//   z          reduction result, meaningful when out_valid
//   out_valid  result valid
//   out_ready  downstream takes the result this cycle
module la_reduce_pipe #(
   parameter int    N     = 4,
   parameter int    FANIN = 4,
   parameter string MODE  = "NAND",
   parameter string PROP  = "DEFAULT"
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic [N-1:0] in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         z,
   output logic         out_valid,
   input  logic         out_ready
);

   function automatic int calc_levels(input int n, input int f);
      int w;
      int l;
      l = 1;
      w = (n + f - 1) / f;
      while (w > 1) begin
         w = (w + f - 1) / f;
         l = l + 1;
      end
      return l;
   endfunction

   localparam int L = calc_levels(N, FANIN);

   localparam bit IS_AND = (MODE == "AND") || (MODE == "NAND");
   localparam bit IS_OR  = (MODE == "OR")  || (MODE == "NOR");
   localparam bit IS_XOR = (MODE == "XOR") || (MODE == "XNOR");
   localparam bit INV    = (MODE == "NAND") || (MODE == "NOR") || (MODE == "XNOR");
   // Identity value used to pad node inputs that fall beyond the operand width.
   localparam bit IDENT  = IS_AND;

   generate
      if (!(IS_AND || IS_OR || IS_XOR)) begin : g_bad_mode
         $fatal(1, "la_reduce_pipe: unsupported MODE %s (PROP %s)", MODE, PROP);
      end
   endgenerate

   logic [N-1:0] stage_q [1:L];
   logic [N-1:0] stage_d [1:L];
   logic [N-1:0] src     [0:L-1];
   logic [L:1]   v_q;
   logic [L:0]   v_chain;
   logic [L:1]   rdy;
   logic         unused_top;

   // v_chain[k-1] is the valid feeding stage k; index 0 is the input port.
   assign v_chain = {v_q, in_valid};

   always_comb begin
      src[0] = in;
      for (int k = 1; k < L; k++) begin
         src[k] = stage_q[k];
      end
   end

   // Tree levels. Level k takes ceil(N/FANIN^(k-1)) live bits and produces
   // ceil(N/FANIN^k); everything above the live width stays zero.
   always_comb begin
      int   w_prev;
      int   w_cur;
      int   idx;
      logic acc;
      logic bit_in;
      w_prev = N;
      w_cur  = N;
      idx    = 0;
      acc    = 1'b0;
      bit_in = 1'b0;
      for (int k = 1; k <= L; k++) begin
         stage_d[k] = '0;
         w_cur = (w_prev + FANIN - 1) / FANIN;
         for (int j = 0; j < N; j++) begin
            if (j < w_cur) begin
               acc = IDENT;
               for (int f = 0; f < FANIN; f++) begin
                  idx    = j * FANIN + f;
                  bit_in = IDENT;
                  if (idx < w_prev) begin
                     bit_in = src[k-1][idx];
                  end
                  if (IS_AND) begin
                     acc = acc & bit_in;
                  end else if (IS_OR) begin
                     acc = acc | bit_in;
                  end else begin
                     acc = acc ^ bit_in;
                  end
               end
               stage_d[k][j] = acc;
            end
         end
         w_prev = w_cur;
      end
      // Inner levels stay non-inverted; the inverting modes flip only the
      // single bit entering the last register.
      stage_d[L][0] = stage_d[L][0] ^ INV;
   end

   // Ready ripples back from the output: a stage can load if it is empty or
   // if the stage after it is moving this cycle.
   always_comb begin
      logic r;
      r   = out_ready;
      rdy = '0;
      for (int k = L; k >= 1; k--) begin
         r      = ~v_q[k] | r;
         rdy[k] = r;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         v_q <= '0;
         for (int k = 1; k <= L; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 1; k <= L; k++) begin
            if (rdy[k]) begin
               v_q[k] <= v_chain[k-1];
               // Data only moves with a valid item so z is steady across bubbles.
               if (v_chain[k-1]) begin
                  stage_q[k] <= stage_d[k];
               end
            end
         end
      end
   end

   assign in_ready  = rdy[1];
   assign out_valid = v_q[L];
   assign z         = stage_q[L][0];

   // Only bit 0 of the last stage is live; its upper bits are always zero.
   assign unused_top = ^stage_q[L];

endmodule
